// File: rtl/ntsc_pkg.sv
// Default NTSC 240p/480i timing constants and DAC levels shared by the timing generator.
package ntsc_pkg;

    localparam int NTSC_CNT_W            = 12;
    localparam int NTSC_HLINECYCLES      = 910;
    localparam int NTSC_VLINES           = 263;
    localparam int NTSC_HSYNCCYCLES      = 67;
    localparam int NTSC_VSYNCCYCLES      = 421;
    localparam int NTSC_HACTIVESTART     = 196;
    localparam int NTSC_HACTIVEDURATION  = 640;
    localparam int NTSC_VACTIVESTART     = 40;
    localparam int NTSC_VACTIVEDURATION  = 200;
    localparam int NTSC_BURSTSTART       = 70;
    localparam int NTSC_BURSTDURATION    = 60;
    localparam int NTSC_DRAWNCYCLES      = 32;

    localparam logic [7:0] NTSC_SYNCLEVEL  = 8'd0;
    localparam logic [7:0] NTSC_BLANKLEVEL = 8'd72;

endpackage

// File: rtl/ntsc_window_cnt.sv
// Load/decrement pulse counter: loads on request, then counts down to zero and holds there.
module ntsc_window_cnt #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] loadValue,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= loadValue;
        end else if (count != '0) begin
            count <= count - WIDTH'(1);
        end
    end

endmodule

// File: rtl/ntsc_timing_gen.sv
// NTSC sync/blanking/burst timing generator; define NTSC_INTERLACE_EN for 480i with
// half-line field-1 vsync, otherwise progressive 240p.
module ntsc_timing_gen
    import ntsc_pkg::*;
#(
    parameter int         CNT_W           = NTSC_CNT_W,
    parameter int         HLINECYCLES     = NTSC_HLINECYCLES,
    parameter int         VLINES          = NTSC_VLINES,
    parameter int         HSYNCCYCLES     = NTSC_HSYNCCYCLES,
    parameter int         VSYNCCYCLES     = NTSC_VSYNCCYCLES,
    parameter int         HACTIVESTART    = NTSC_HACTIVESTART,
    parameter int         HACTIVEDURATION = NTSC_HACTIVEDURATION,
    parameter int         VACTIVESTART    = NTSC_VACTIVESTART,
    parameter int         VACTIVEDURATION = NTSC_VACTIVEDURATION,
    parameter int         BURSTSTART      = NTSC_BURSTSTART,
    parameter int         BURSTDURATION   = NTSC_BURSTDURATION,
    parameter logic [7:0] SYNCLEVEL       = NTSC_SYNCLEVEL,
    parameter logic [7:0] BLANKLEVEL      = NTSC_BLANKLEVEL,
    parameter int         DRAWNCYCLES     = NTSC_DRAWNCYCLES
) (
    input  logic             clk,
    input  logic             reset,
    output logic [7:0]       ntscBase,
    output logic             colorburst,
    output logic [1:0]       burstPhase,
    output logic             hsync,
    output logic             vsync,
    output logic             hactive,
    output logic             vactive,
    output logic             field,
    output logic [CNT_W-1:0] hcount,
    output logic [CNT_W-1:0] vcount,
    output logic             frameDrawn
);

    localparam logic [CNT_W-1:0] H_LAST  = CNT_W'(HLINECYCLES - 1);
    localparam logic [CNT_W-1:0] H_HALF  = CNT_W'(HLINECYCLES / 2);
    localparam logic [CNT_W-1:0] HS_END  = CNT_W'(HSYNCCYCLES);
    localparam logic [CNT_W-1:0] HA_BEG  = CNT_W'(HACTIVESTART);
    localparam logic [CNT_W-1:0] HA_END  = CNT_W'(HACTIVESTART + HACTIVEDURATION);
    localparam logic [CNT_W-1:0] VA_BEG  = CNT_W'(VACTIVESTART);
    localparam logic [CNT_W-1:0] VA_END  = CNT_W'(VACTIVESTART + VACTIVEDURATION);
    localparam logic [CNT_W-1:0] BU_BEG  = CNT_W'(BURSTSTART);
    localparam logic [CNT_W-1:0] BU_END  = CNT_W'(BURSTSTART + BURSTDURATION);
    localparam logic [CNT_W-1:0] V_LAST0 = CNT_W'(VLINES - 1);
    localparam int               VS_W    = $clog2(VSYNCCYCLES + 1);
    localparam int               DR_W    = $clog2(DRAWNCYCLES + 1);

    logic             hWrap;
    logic             vWrap;
    logic             vsStart;
    logic             drawnStart;
    logic [CNT_W-1:0] fieldLast;
    logic [CNT_W-1:0] vsyncStartCol;
    logic [VS_W-1:0]  vsyncCnt;
    logic [DR_W-1:0]  drawnCnt;

    // Raster position and the subcarrier phase, which runs freely across line boundaries.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hcount     <= '0;
            vcount     <= '0;
            burstPhase <= 2'd0;
        end else begin
            burstPhase <= burstPhase + 2'd1;
            if (hWrap) begin
                hcount <= '0;
                vcount <= vWrap ? '0 : vcount + CNT_W'(1);
            end else begin
                hcount <= hcount + CNT_W'(1);
            end
        end
    end

`ifdef NTSC_INTERLACE_EN
    localparam logic [CNT_W-1:0] V_LAST1 = CNT_W'(VLINES - 2);

    // Field flips together with the vcount wrap, so the field-1 half-line vsync sees the new value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            field <= 1'b0;
        end else if (vWrap) begin
            field <= ~field;
        end
    end

    assign fieldLast     = field ? V_LAST1 : V_LAST0;
    assign vsyncStartCol = field ? H_HALF : '0;
`else
    assign field         = 1'b0;
    assign fieldLast     = V_LAST0;
    assign vsyncStartCol = '0;
`endif

    always_comb begin
        hWrap      = (hcount == H_LAST);
        vWrap      = hWrap && (vcount == fieldLast);
        vsStart    = (vcount == '0) && (hcount == vsyncStartCol);
        drawnStart = (vcount == '0) && (hcount == '0) && !field;
    end

    ntsc_window_cnt #(.WIDTH(VS_W)) vsyncWindow (
        .clk       (clk),
        .reset     (reset),
        .load      (vsStart),
        .loadValue (VS_W'(VSYNCCYCLES - 1)),
        .count     (vsyncCnt)
    );

    ntsc_window_cnt #(.WIDTH(DR_W)) drawnWindow (
        .clk       (clk),
        .reset     (reset),
        .load      (drawnStart),
        .loadValue (DR_W'(DRAWNCYCLES - 1)),
        .count     (drawnCnt)
    );

    // The start condition itself covers the first clock, so pulses appear in the reset cycle too.
    always_comb begin
        vsync      = vsStart || (vsyncCnt != '0);
        frameDrawn = drawnStart || (drawnCnt != '0);
        hsync      = (hcount < HS_END);
        hactive    = (hcount >= HA_BEG) && (hcount < HA_END);
        vactive    = (vcount >= VA_BEG) && (vcount < VA_END);
        colorburst = !vsync && (hcount >= BU_BEG) && (hcount < BU_END);
        ntscBase   = (hsync || vsync) ? SYNCLEVEL : BLANKLEVEL;
    end

endmodule

// File: tb/tb_ntsc_timing_gen.sv
// Directed bench for ntsc_timing_gen using a short 8-line field and a 1000-clock vsync.
module tb_ntsc_timing_gen;

    localparam int CNT_W = 12;

`ifdef NTSC_INTERLACE_EN
    localparam int RESET_CYC = 25980;
`else
    localparam int RESET_CYC = 12330;
`endif

    logic             clk;
    logic             reset;
    logic [7:0]       ntscBase;
    logic             colorburst;
    logic [1:0]       burstPhase;
    logic             hsync;
    logic             vsync;
    logic             hactive;
    logic             vactive;
    logic             field;
    logic [CNT_W-1:0] hcount;
    logic [CNT_W-1:0] vcount;
    logic             frameDrawn;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    ntsc_timing_gen #(
        .CNT_W           (CNT_W),
        .VLINES          (8),
        .VSYNCCYCLES     (1000),
        .VACTIVESTART    (3),
        .VACTIVEDURATION (2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .ntscBase   (ntscBase),
        .colorburst (colorburst),
        .burstPhase (burstPhase),
        .hsync      (hsync),
        .vsync      (vsync),
        .hactive    (hactive),
        .vactive    (vactive),
        .field      (field),
        .hcount     (hcount),
        .vcount     (vcount),
        .frameDrawn (frameDrawn)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", tag, cyc, actual, expected);
        end
    endtask

    // Advance to the negedge after the given number of rising edges since the last reset release.
    task automatic applyStimulus(input int target);
        while (cyc < target) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    initial begin
        reset = 1'b1;
        @(negedge clk);
        checkOutput("rst_hcount", int'(hcount), 0);
        checkOutput("rst_vcount", int'(vcount), 0);
        checkOutput("rst_vsync", int'(vsync), 1);
        checkOutput("rst_drawn", int'(frameDrawn), 1);
        checkOutput("rst_base", int'(ntscBase), 0);
        checkOutput("rst_phase", int'(burstPhase), 0);
        reset = 1'b0;
        cyc   = 0;

        applyStimulus(1);
        checkOutput("h_first", int'(hcount), 1);
        applyStimulus(31);
        checkOutput("drawn_last", int'(frameDrawn), 1);
        applyStimulus(32);
        checkOutput("drawn_end", int'(frameDrawn), 0);
        applyStimulus(909);
        checkOutput("h_last", int'(hcount), 909);
        checkOutput("v_before_wrap", int'(vcount), 0);
        applyStimulus(910);
        checkOutput("h_wrap", int'(hcount), 0);
        checkOutput("v_line1", int'(vcount), 1);
        checkOutput("phase_line1", int'(burstPhase), 2);
        applyStimulus(990);
        checkOutput("burst_masked", int'(colorburst), 0);
        applyStimulus(999);
        checkOutput("vs_last_h", int'(hcount), 89);
        checkOutput("vs_last", int'(vsync), 1);
        applyStimulus(1000);
        checkOutput("vs_end", int'(vsync), 0);
        checkOutput("burst_unmask", int'(colorburst), 1);
        applyStimulus(1039);
        checkOutput("burst_last", int'(colorburst), 1);
        applyStimulus(1040);
        checkOutput("burst_after", int'(colorburst), 0);

        applyStimulus(2729);
        checkOutput("vact_before", int'(vactive), 0);
        applyStimulus(2730);
        checkOutput("vact_begin", int'(vactive), 1);
        applyStimulus(3650);
        checkOutput("vact_line4", int'(vactive), 1);

        applyStimulus(4550 + 66);
        checkOutput("l5_hs_last", int'(hsync), 1);
        checkOutput("l5_base_sync", int'(ntscBase), 0);
        applyStimulus(4550 + 67);
        checkOutput("l5_hs_end", int'(hsync), 0);
        checkOutput("l5_base_blank", int'(ntscBase), 72);
        checkOutput("vact_line5", int'(vactive), 0);
        applyStimulus(4550 + 69);
        checkOutput("l5_burst_pre", int'(colorburst), 0);
        applyStimulus(4550 + 70);
        checkOutput("l5_burst_on", int'(colorburst), 1);
        applyStimulus(4550 + 129);
        checkOutput("l5_burst_last", int'(colorburst), 1);
        applyStimulus(4550 + 130);
        checkOutput("l5_burst_off", int'(colorburst), 0);
        applyStimulus(4550 + 195);
        checkOutput("l5_hact_pre", int'(hactive), 0);
        applyStimulus(4550 + 196);
        checkOutput("l5_hact_on", int'(hactive), 1);
        applyStimulus(4550 + 835);
        checkOutput("l5_hact_last", int'(hactive), 1);
        applyStimulus(4550 + 836);
        checkOutput("l5_hact_off", int'(hactive), 0);

        applyStimulus(7279);
        checkOutput("f0_end_v", int'(vcount), 7);
        checkOutput("f0_end_vs", int'(vsync), 0);
        checkOutput("f0_end_drawn", int'(frameDrawn), 0);
        applyStimulus(7280);
        checkOutput("f1_start_v", int'(vcount), 0);
        checkOutput("f1_start_h", int'(hcount), 0);
        checkOutput("f1_start_phase", int'(burstPhase), 0);
`ifdef NTSC_INTERLACE_EN
        checkOutput("f1_field", int'(field), 1);
        checkOutput("f1_vs_idle", int'(vsync), 0);
        checkOutput("f1_no_drawn", int'(frameDrawn), 0);
        applyStimulus(7280 + 454);
        checkOutput("f1_vs_pre_half", int'(vsync), 0);
        applyStimulus(7280 + 455);
        checkOutput("f1_vs_half", int'(vsync), 1);
        applyStimulus(7280 + 455 + 999);
        checkOutput("f1_vs_last", int'(vsync), 1);
        applyStimulus(7280 + 455 + 1000);
        checkOutput("f1_vs_end", int'(vsync), 0);
        applyStimulus(13649);
        checkOutput("f1_end_v", int'(vcount), 6);
        checkOutput("f1_end_drawn", int'(frameDrawn), 0);
        applyStimulus(13650);
        checkOutput("fr2_field", int'(field), 0);
        checkOutput("fr2_v", int'(vcount), 0);
        checkOutput("fr2_vs", int'(vsync), 1);
        checkOutput("fr2_drawn", int'(frameDrawn), 1);
        applyStimulus(13650 + 31);
        checkOutput("fr2_drawn_last", int'(frameDrawn), 1);
        applyStimulus(13650 + 32);
        checkOutput("fr2_drawn_end", int'(frameDrawn), 0);
`else
        checkOutput("fr2_field", int'(field), 0);
        checkOutput("fr2_vs", int'(vsync), 1);
        checkOutput("fr2_drawn", int'(frameDrawn), 1);
        applyStimulus(7280 + 31);
        checkOutput("fr2_drawn_last", int'(frameDrawn), 1);
        applyStimulus(7280 + 32);
        checkOutput("fr2_drawn_end", int'(frameDrawn), 0);
        applyStimulus(7280 + 999);
        checkOutput("fr2_vs_last", int'(vsync), 1);
        applyStimulus(7280 + 1000);
        checkOutput("fr2_vs_end", int'(vsync), 0);
`endif

        applyStimulus(RESET_CYC);
        checkOutput("pre_rst_h", int'(hcount), 500);
        checkOutput("pre_rst_v", int'(vcount), 5);
`ifdef NTSC_INTERLACE_EN
        checkOutput("pre_rst_field", int'(field), 1);
`endif
        #2;
        reset = 1'b1;
        #1;
        checkOutput("async_h", int'(hcount), 0);
        checkOutput("async_v", int'(vcount), 0);
        checkOutput("async_field", int'(field), 0);
        checkOutput("async_phase", int'(burstPhase), 0);
        checkOutput("async_vs", int'(vsync), 1);
        checkOutput("async_drawn", int'(frameDrawn), 1);
        @(negedge clk);
        checkOutput("held_h", int'(hcount), 0);
        reset = 1'b0;
        cyc   = 0;
        applyStimulus(1);
        checkOutput("resume_h", int'(hcount), 1);
        checkOutput("resume_v", int'(vcount), 0);
        checkOutput("resume_phase", int'(burstPhase), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
